// File: rtl/cprv_ram_1p_pipe_pkg.sv
// Shared types and helpers for the cprv single-port RAM with a valid/ready response FIFO.
package cprv_ram_pkg;

  // Widest word the response FIFO entry can carry.
  localparam int RAM_RESP_DW = 64;

  typedef struct packed {
    logic [RAM_RESP_DW-1:0] data;
    logic                   we;
  } ram_resp_t;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic bit params_ok(input int data_width, input int out_depth);
    return (data_width % 8 == 0) && (data_width > 0) &&
           (data_width <= RAM_RESP_DW) && (out_depth >= 2);
  endfunction

endpackage

// File: rtl/cprv_ram_1p_pipe_if.sv
// Request/response bundle between a requesting stage (master) and the RAM (slave).
interface cprv_ram_1p_pipe_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
) ();
  import cprv_ram_pkg::*;

  logic                                valid_i;
  logic                                ready_o;
  logic                                w_en;
  logic [ADDR_WIDTH-1:0]               addr;
  logic [DATA_WIDTH-1:0]               wdata;
  logic [strb_width(DATA_WIDTH)-1:0]   wstrb;
  logic                                valid_o;
  logic                                ready_i;
  logic [DATA_WIDTH-1:0]               rdata;
  logic                                resp_we;

  modport master (
    output valid_i, w_en, addr, wdata, wstrb, ready_i,
    input  ready_o, valid_o, rdata, resp_we
  );

  modport slave (
    input  valid_i, w_en, addr, wdata, wstrb, ready_i,
    output ready_o, valid_o, rdata, resp_we
  );

endinterface

// File: rtl/cprv_ram_1p_pipe_core.sv
// Single-port storage array: byte-strobed write, registered read that holds when idle.
module cprv_ram_1p_core
  import cprv_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              en,
  input  logic                              we,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic [strb_width(DATA_WIDTH)-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]             rdata
);

  localparam int SW = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_p1;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < SW; b++) begin
        if (wstrb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (en && !we) rdata_p1 <= mem[addr];
  end

  assign rdata = rdata_p1;

endmodule

// File: rtl/cprv_ram_1p_pipe.sv
// RAM with in-order response FIFO and bypass; ready_o depends on registered state only.
// Define CPRV_RAM_WRESP_EN to make writes return a response beat (resp_we=1, rdata=0).
module cprv_ram_1p_pipe
  import cprv_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int OUT_DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cprv_ram_1p_pipe_if.slave        bus
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = $clog2(OUT_DEPTH);

  generate
    if (!params_ok(DATA_WIDTH, OUT_DEPTH)) begin : g_bad_params
      $error("cprv_ram_1p_pipe: DATA_WIDTH must be a multiple of 8 within RAM_RESP_DW, OUT_DEPTH >= 2");
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic                  acc;
  logic                  issue;
  logic                  issue_we;
  logic                  inflight;
  logic                  inflight_we;
  logic [DATA_WIDTH-1:0] core_rdata;
  ram_resp_t             core_resp;
  ram_resp_t             head;
  ram_resp_t             fifo_q [OUT_DEPTH];
  logic [CNT_W-1:0]      fifo_cnt;
  logic [CNT_W:0]        occ;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  fifo_empty;
  logic                  push;
  logic                  fifo_pop;

  assign acc = bus.valid_i & bus.ready_o;

`ifdef CPRV_RAM_WRESP_EN
  assign issue    = acc;
  assign issue_we = bus.w_en;
`else
  assign issue    = acc & ~bus.w_en;
  assign issue_we = 1'b0;
`endif

  // Stage p0 -> p1: request into the array
  cprv_ram_1p_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .en    (acc),
    .we    (bus.w_en),
    .addr  (bus.addr),
    .wdata (bus.wdata),
    .wstrb (bus.wstrb),
    .rdata (core_rdata)
  );

  // Stage p1: bypass to the outputs or park in the FIFO
  always_comb begin
    core_resp.data = inflight_we ? '0 : RAM_RESP_DW'(core_rdata);
    core_resp.we   = inflight_we;
  end

  assign fifo_empty  = (fifo_cnt == '0);
  assign head        = fifo_empty ? core_resp : fifo_q[rd_ptr];
  assign bus.valid_o = fifo_empty ? inflight : 1'b1;
  assign bus.rdata   = head.data[DATA_WIDTH-1:0];
  assign bus.resp_we = head.we;

  assign push     = inflight & ~(fifo_empty & bus.ready_i);
  assign fifo_pop = bus.ready_i & ~fifo_empty;

  assign occ         = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight};
  assign bus.ready_o = occ < (CNT_W + 1)'(OUT_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      inflight_we <= 1'b0;
      fifo_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      inflight    <= issue;
      inflight_we <= issue & issue_we;
      if (push)     wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= core_resp;
  end

endmodule
